// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage: access-size codes, the MEM/WB
// register layout, and the byte-lane placement/extraction functions.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } mem_size_e;

   typedef struct packed {
      logic [31:0] data_alu;
      logic        MemToReg;
      logic        RegWrite;
      logic [4:0]  write_reg;
      logic        is_load;
      logic [1:0]  offset;
      mem_size_e   size;
      logic        is_unsigned;
   } wb_reg_t;

   localparam wb_reg_t WB_BUBBLE = '0;

   function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return addr[0];
         default:   return addr != 2'b00;
      endcase
   endfunction

   // Misaligned sub-word addresses are pulled down to the natural boundary.
   function automatic logic [1:0] align_offset(input mem_size_e size, input logic [1:0] addr);
      case (size)
         SIZE_BYTE: return addr;
         SIZE_HALF: return {addr[1], 1'b0};
         default:   return 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] byte_enable(input mem_size_e size, input logic [1:0] offset);
      case (size)
         SIZE_BYTE: return 4'b0001 << offset;
         SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
         default:   return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input mem_size_e size, input logic [31:0] wdata);
      case (size)
         SIZE_BYTE: return {4{wdata[7:0]}};
         SIZE_HALF: return {2{wdata[15:0]}};
         default:   return wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] raw, input logic [1:0] offset,
                                                input mem_size_e size, input logic is_unsigned);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(raw >> {offset, 3'b000});
      h = 16'(raw >> {offset[1], 4'b0000});
      case (size)
         SIZE_BYTE: return is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
         SIZE_HALF: return is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
         default:   return raw;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_dmem_ram.sv
// Word-organised synchronous data RAM with per-byte write enables; reads return the
// contents from before a same-edge write (read-first).
module dmem_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (rd_en) rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte-lane stores/loads into dmem_ram plus the MEM/WB register.
// Optional macro MISALIGN_TRAP_EN turns misaligned accesses into traps reported on misalign_w.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_m,
   input  logic              flush_m,
   input  logic              MemRead_m,
   input  logic              MemWrite_m,
   input  logic              MemToReg_m,
   input  logic              RegWrite_m,
   input  logic [1:0]        size_m,
   input  logic              unsigned_m,
   input  logic [DATA_W-1:0] alu_result_m,
   input  logic [DATA_W-1:0] write_data_m,
   input  logic [4:0]        write_reg_m,
   output logic [DATA_W-1:0] data_mem_w,
   output logic [DATA_W-1:0] data_alu_w,
   output logic              MemToReg_w,
   output logic              RegWrite_w,
`ifdef MISALIGN_TRAP_EN
   output logic              misalign_w,
`endif
   output logic [4:0]        write_reg_w
);

   mem_size_e   size;
   logic [1:0]  offset;
   logic        trap;
   logic        store_en;
   logic [3:0]  we;
   logic [31:0] raw;
   wb_reg_t     wb;
   wb_reg_t     wb_next;

   assign size   = mem_size_e'(size_m);
   assign offset = align_offset(size, alu_result_m[1:0]);

`ifdef MISALIGN_TRAP_EN
   assign trap = (MemRead_m | MemWrite_m) & is_misaligned(size, alu_result_m[1:0]);
`else
   assign trap = 1'b0;
`endif

   assign store_en = MemWrite_m & ~rst & ~flush_m & ~stall_m & ~trap;
   assign we       = store_en ? byte_enable(size, offset) : 4'b0000;

   // The read port is frozen during a stall so the held load keeps its raw word.
   dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .rd_en (~stall_m),
      .we    (we),
      .addr  (alu_result_m[ADDR_W+1:2]),
      .wdata (store_lanes(size, write_data_m)),
      .rdata (raw)
   );

   always_comb begin
      wb_next             = WB_BUBBLE;
      wb_next.data_alu    = alu_result_m;
      wb_next.MemToReg    = MemToReg_m;
      wb_next.RegWrite    = RegWrite_m & ~trap;
      wb_next.write_reg   = write_reg_m;
      wb_next.is_load     = MemRead_m & ~trap;
      wb_next.offset      = offset;
      wb_next.size        = size;
      wb_next.is_unsigned = unsigned_m;
   end

   always_ff @(posedge clk) begin
      if (rst || flush_m) wb <= WB_BUBBLE;
      else if (!stall_m)  wb <= wb_next;
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (rst || flush_m) misalign_w <= 1'b0;
      else if (!stall_m)  misalign_w <= trap;
   end
`endif

   assign data_mem_w  = wb.is_load ? load_extract(raw, wb.offset, wb.size, wb.is_unsigned) : '0;
   assign data_alu_w  = wb.data_alu;
   assign MemToReg_w  = wb.MemToReg;
   assign RegWrite_w  = wb.RegWrite;
   assign write_reg_w = wb.write_reg;

endmodule
